// File: rtl/mau_controller_if.sv
// ============================================================================
// Module      : mau_controller_if
// Description : Bundle of host command/response streams and the CPU-facing
//               memory-access, run-control and status signals for the
//               mau_controller.
//               master : the controller side (drives cmd_ready, rsp_*,
//                        mau_address_*, mau_write_data_*, mau_wren_*, alive,
//                        busy).
//               slave  : the host + CPU side (drives cmd_valid/cmd_data,
//                        rsp_ready, mau_read_data_*, halt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mau_controller_if;
    // Host command stream
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    // Host response stream
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    // CPU memory access ports
    logic [31:0] mau_address_im;
    logic [31:0] mau_address_dm;
    logic [31:0] mau_address_rf;
    logic [31:0] mau_write_data_im;
    logic [31:0] mau_write_data_dm;
    logic [31:0] mau_write_data_rf;
    logic        mau_wren_im;
    logic        mau_wren_dm;
    logic        mau_wren_rf;
    logic [31:0] mau_read_data_im;
    logic [31:0] mau_read_data_dm;
    logic [31:0] mau_read_data_rf;
    // Run control / status
    logic        alive;
    logic        halt;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_data, rsp_ready,
        input  mau_read_data_im, mau_read_data_dm, mau_read_data_rf, halt,
        output cmd_ready, rsp_valid, rsp_data,
        output mau_address_im, mau_address_dm, mau_address_rf,
        output mau_write_data_im, mau_write_data_dm, mau_write_data_rf,
        output mau_wren_im, mau_wren_dm, mau_wren_rf,
        output alive, busy
    );

    modport slave (
        output cmd_valid, cmd_data, rsp_ready,
        output mau_read_data_im, mau_read_data_dm, mau_read_data_rf, halt,
        input  cmd_ready, rsp_valid, rsp_data,
        input  mau_address_im, mau_address_dm, mau_address_rf,
        input  mau_write_data_im, mau_write_data_dm, mau_write_data_rf,
        input  mau_wren_im, mau_wren_dm, mau_wren_rf,
        input  alive, busy
    );
endinterface

`default_nettype wire

// File: rtl/mau_controller.sv
// ============================================================================
// Module      : mau_controller
// Description : Host-side memory access unit in front of the CPU. Decodes a
//               32-bit command stream to load/read IM, DM and RF, and to run
//               the CPU (alive) until halt or a cycle limit, reporting the
//               cycle count on the response stream.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - mau_controller_if.master (cmd/rsp streams, mau_*,
//                      alive, halt, busy)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mau_controller #(
    parameter logic [31:0] MAX_CYCLES   = 32'd1_000_000,
    parameter int          READ_LATENCY = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mau_controller_if.master  bus
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_wr      = 3'd1;
    localparam logic [2:0] c_st_rd_addr = 3'd2;
    localparam logic [2:0] c_st_rd_wait = 3'd3;
    localparam logic [2:0] c_st_rd_push = 3'd4;
    localparam logic [2:0] c_st_run     = 3'd5;
    localparam logic [2:0] c_st_run_rsp = 3'd6;

    localparam logic [1:0] c_tgt_im  = 2'b00;
    localparam logic [1:0] c_tgt_dm  = 2'b01;
    localparam logic [1:0] c_tgt_run = 2'b11;

    // RD_WAIT lasts READ_LATENCY cycles; the counter runs down to zero.
    localparam logic [2:0] c_lat_init = 3'(READ_LATENCY - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_target;
    logic [12:0] r_idx;
    logic [15:0] r_remaining;
    logic [2:0]  r_lat;
    logic [31:0] r_cycles;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [31:0] r_addr_im;
    logic [31:0] r_addr_dm;
    logic [31:0] r_addr_rf;
    logic [31:0] r_wdata;
    logic        r_wren_im;
    logic        r_wren_dm;
    logic        r_wren_rf;
    logic        r_alive;

    // Header fields
    logic        w_hdr_op;
    logic [1:0]  w_hdr_tgt;
    logic [12:0] w_hdr_base;
    logic [15:0] w_hdr_count;

    logic        w_hdr_fire;
    logic        w_wr_fire;
    logic        w_push_fire;
    logic        w_last;
    logic        w_rd_start;
    logic        w_addr_load;
    logic [1:0]  w_addr_tgt;
    logic [12:0] w_addr_idx;
    logic [31:0] w_addr_val;
    logic [31:0] w_cyc_next;
    logic        w_timeout;
    logic [30:0] w_cyc_sat;
    logic [31:0] w_rd_data;

    assign w_hdr_op    = bus.cmd_data[31];
    assign w_hdr_tgt   = bus.cmd_data[30:29];
    assign w_hdr_base  = bus.cmd_data[28:16];
    assign w_hdr_count = bus.cmd_data[15:0];

    assign w_hdr_fire  = (r_state == c_st_idle) && bus.cmd_valid && r_cmd_ready;
    assign w_wr_fire   = (r_state == c_st_wr) && bus.cmd_valid && r_cmd_ready;
    assign w_push_fire = (r_state == c_st_rd_push) && bus.rsp_ready;
    assign w_last      = (r_remaining == 16'd1);
    assign w_rd_start  = w_hdr_fire && w_hdr_op && (w_hdr_tgt != c_tgt_run)
                         && (w_hdr_count != 16'd0);

    // The address register of the selected target is loaded on each write
    // word, at read start, and when advancing to the next read word, so that
    // it is already stable during the RD_ADDR cycle.
    assign w_addr_load = w_rd_start || w_wr_fire || (w_push_fire && !w_last);
    assign w_addr_tgt  = w_hdr_fire ? w_hdr_tgt : r_target;
    assign w_addr_idx  = w_hdr_fire  ? w_hdr_base :
                         w_push_fire ? (r_idx + 13'd1) : r_idx;
    assign w_addr_val  = {17'd0, w_addr_idx, 2'b00};

    // Count including the current alive cycle; never wraps because the run
    // stops as soon as it reaches MAX_CYCLES.
    assign w_cyc_next  = r_cycles + 32'd1;
    assign w_timeout   = (w_cyc_next >= MAX_CYCLES);
    assign w_cyc_sat   = w_cyc_next[31] ? 31'h7FFF_FFFF : w_cyc_next[30:0];

    always_comb begin
        w_rd_data = bus.mau_read_data_rf;
        case (r_target)
            c_tgt_im: w_rd_data = bus.mau_read_data_im;
            c_tgt_dm: w_rd_data = bus.mau_read_data_dm;
            default:  w_rd_data = bus.mau_read_data_rf;
        endcase
    end

    // Memory-side datapath: addresses, shared write data, one-cycle strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_im <= 32'd0;
            r_addr_dm <= 32'd0;
            r_addr_rf <= 32'd0;
            r_wdata   <= 32'd0;
            r_wren_im <= 1'b0;
            r_wren_dm <= 1'b0;
            r_wren_rf <= 1'b0;
        end else begin
            r_wren_im <= 1'b0;
            r_wren_dm <= 1'b0;
            r_wren_rf <= 1'b0;
            if (w_addr_load) begin
                case (w_addr_tgt)
                    c_tgt_im: r_addr_im <= w_addr_val;
                    c_tgt_dm: r_addr_dm <= w_addr_val;
                    default:  r_addr_rf <= w_addr_val;
                endcase
            end
            if (w_wr_fire) begin
                r_wdata <= bus.cmd_data;
                case (r_target)
                    c_tgt_im: r_wren_im <= 1'b1;
                    c_tgt_dm: r_wren_dm <= 1'b1;
                    default:  r_wren_rf <= 1'b1;
                endcase
            end
        end
    end

    // Control state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_target    <= 2'b00;
            r_idx       <= 13'd0;
            r_remaining <= 16'd0;
            r_lat       <= 3'd0;
            r_cycles    <= 32'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_alive     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_cmd_ready <= 1'b1;
                    if (w_hdr_fire) begin
                        r_target    <= w_hdr_tgt;
                        r_idx       <= w_hdr_base;
                        r_remaining <= w_hdr_count;
                        if (w_hdr_tgt == c_tgt_run) begin
                            r_state     <= c_st_run;
                            r_alive     <= 1'b1;
                            r_cycles    <= 32'd0;
                            r_cmd_ready <= 1'b0;
                        end else if (w_hdr_count == 16'd0) begin
                            r_state <= c_st_idle;
                        end else if (!w_hdr_op) begin
                            r_state <= c_st_wr;
                        end else begin
                            r_state     <= c_st_rd_addr;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                c_st_wr: begin
                    if (w_wr_fire) begin
                        r_idx       <= r_idx + 13'd1;
                        r_remaining <= r_remaining - 16'd1;
                        if (w_last) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_rd_addr: begin
                    r_state <= c_st_rd_wait;
                    r_lat   <= c_lat_init;
                end
                c_st_rd_wait: begin
                    if (r_lat == 3'd0) begin
                        r_rsp_data  <= w_rd_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_st_rd_push;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                c_st_rd_push: begin
                    if (w_push_fire) begin
                        r_rsp_valid <= 1'b0;
                        r_remaining <= r_remaining - 16'd1;
                        if (w_last) begin
                            r_state     <= c_st_idle;
                            r_cmd_ready <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 13'd1;
                            r_state <= c_st_rd_addr;
                        end
                    end
                end
                c_st_run: begin
                    r_cycles <= w_cyc_next;
                    // Halt takes priority over the limit, so the flag is
                    // only set when halt is low in the ending cycle.
                    if (bus.halt || w_timeout) begin
                        r_alive     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= {!bus.halt, w_cyc_sat};
                        r_state     <= c_st_run_rsp;
                    end
                end
                c_st_run_rsp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_st_idle;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_cmd_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_alive     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready         = r_cmd_ready;
    assign bus.rsp_valid         = r_rsp_valid;
    assign bus.rsp_data          = r_rsp_data;
    assign bus.mau_address_im    = r_addr_im;
    assign bus.mau_address_dm    = r_addr_dm;
    assign bus.mau_address_rf    = r_addr_rf;
    assign bus.mau_write_data_im = r_wdata;
    assign bus.mau_write_data_dm = r_wdata;
    assign bus.mau_write_data_rf = r_wdata;
    assign bus.mau_wren_im       = r_wren_im;
    assign bus.mau_wren_dm       = r_wren_dm;
    assign bus.mau_wren_rf       = r_wren_rf;
    assign bus.alive             = r_alive;
    assign bus.busy              = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_mau_controller.sv
// ============================================================================
// Module      : tb_mau_controller
// Description : Directed self-checking bench for mau_controller. A default
//               instance covers load/read/run/reset; a second instance with
//               a 16-cycle limit covers the watchdog paths. RF read data is
//               modelled as an address-derived pattern behind a 2-cycle pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mau_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mau_controller_if bus ();
    mau_controller_if bus2 ();

    mau_controller #(.MAX_CYCLES(32'd1_000_000), .READ_LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mau_controller #(.MAX_CYCLES(32'd16), .READ_LATENCY(2)) dut_short (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // RF read port: data for address A appears two cycles after A is driven
    logic [31:0] rf_p0, rf_p1;
    always @(posedge clk) begin
        rf_p0 <= 32'hF00D_0000 ^ bus.mau_address_rf;
        rf_p1 <= rf_p0;
    end
    assign bus.mau_read_data_rf  = rf_p1;
    assign bus.mau_read_data_im  = 32'h1111_0000;
    assign bus.mau_read_data_dm  = 32'h2222_0000;
    assign bus2.mau_read_data_im = 32'd0;
    assign bus2.mau_read_data_dm = 32'd0;
    assign bus2.mau_read_data_rf = 32'd0;

    // Alive-cycle counters sampled at each rising edge
    int alive_cnt  = 0;
    int alive_cnt2 = 0;
    always @(posedge clk) begin
        if (bus.alive)  alive_cnt  <= alive_cnt + 1;
        if (bus2.alive) alive_cnt2 <= alive_cnt2 + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] wr_words [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    logic [31:0] rd_exp   [2] = '{32'hF00D_0008, 32'hF00D_000C};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        bus.cmd_valid  = 1'b0;  bus.cmd_data  = 32'd0;
        bus.rsp_ready  = 1'b0;  bus.halt      = 1'b0;
        bus2.cmd_valid = 1'b0;  bus2.cmd_data = 32'd0;
        bus2.rsp_ready = 1'b0;  bus2.halt     = 1'b0;
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data",  bus.rsp_data, 32'd0);
        check("rst_alive_busy", {30'd0, bus.alive, bus.busy}, 32'd0);
        check("rst_wren", {29'd0, bus.mau_wren_im, bus.mau_wren_dm, bus.mau_wren_rf}, 32'd0);
        check("rst_addr_wdata", bus.mau_address_im | bus.mau_address_dm | bus.mau_address_rf
                                | bus.mau_write_data_im, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Write three words to IM starting at index 0
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h0000_0003;
        tick();
        check("wr_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.cmd_data = wr_words[i];
            tick();
            check("wr_im_wren", {31'd0, bus.mau_wren_im}, 32'd1);
            check("wr_im_addr", bus.mau_address_im, 32'(i * 4));
            check("wr_im_data", bus.mau_write_data_im, wr_words[i]);
            check("wr_im_other_wren", {30'd0, bus.mau_wren_dm, bus.mau_wren_rf}, 32'd0);
        end
        bus.cmd_valid = 1'b0;
        check("wr_done_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        check("wr_im_wren_off", {31'd0, bus.mau_wren_im}, 32'd0);

        // DM write wrapping from index 0x1FFF to 0
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h3FFF_0002;
        tick();
        bus.cmd_data  = 32'h1111_1111;
        tick();
        check("wrap_addr0", bus.mau_address_dm, 32'h0000_7FFC);
        check("wrap_wren0", {31'd0, bus.mau_wren_dm}, 32'd1);
        bus.cmd_data  = 32'h2222_2222;
        tick();
        check("wrap_addr1", bus.mau_address_dm, 32'h0000_0000);
        check("wrap_data1", bus.mau_write_data_dm, 32'h2222_2222);
        bus.cmd_valid = 1'b0;
        check("wrap_im_addr_held", bus.mau_address_im, 32'h0000_0008);

        // N = 0 read: no response, back in IDLE
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h8000_0000;
        tick();
        bus.cmd_valid = 1'b0;
        check("n0_busy", {31'd0, bus.busy}, 32'd0);
        check("n0_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        check("n0_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

        // Read RF index 2..3 with a stall before each accept
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'hC002_0002;
        tick();
        bus.cmd_valid = 1'b0;
        check("rd_addr0", bus.mau_address_rf, 32'h0000_0008);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!bus.rsp_valid && n < 50) begin
                tick();
                n++;
            end
            check("rd_latency", 32'(n), 32'd3);
            check("rd_data", bus.rsp_data, rd_exp[k]);
            bus.rsp_ready = 1'b0;
            tick();
            check("rd_stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("rd_stall_data", bus.rsp_data, rd_exp[k]);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            check("rd_accept_valid", {31'd0, bus.rsp_valid}, 32'd0);
            if (k == 0) check("rd_addr1", bus.mau_address_rf, 32'h0000_000C);
        end
        check("rd_done_busy", {31'd0, bus.busy}, 32'd0);

        // RUN, halt in the 50th alive cycle
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h6000_0000;
        tick();
        bus.cmd_valid = 1'b0;
        base = alive_cnt;
        check("run_alive_rise", {31'd0, bus.alive}, 32'd1);
        check("run_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        repeat (49) tick();
        check("run_alive_49", {31'd0, bus.alive}, 32'd1);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("run_alive_fall", {31'd0, bus.alive}, 32'd0);
        check("run_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("run_rsp_data", bus.rsp_data, 32'h0000_0032);
        check("run_alive_cycles", 32'(alive_cnt - base), 32'd50);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("run_done_busy", {31'd0, bus.busy}, 32'd0);

        // Watchdog instance: no halt -> timeout after 16 cycles
        bus2.cmd_valid = 1'b1;
        bus2.cmd_data  = 32'h6000_0000;
        tick();
        bus2.cmd_valid = 1'b0;
        base = alive_cnt2;
        n = 0;
        while (!bus2.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check("to_cycles_to_rsp", 32'(n), 32'd16);
        check("to_rsp_data", bus2.rsp_data, 32'h8000_0010);
        check("to_alive_cycles", 32'(alive_cnt2 - base), 32'd16);
        bus2.rsp_ready = 1'b1;
        tick();
        bus2.rsp_ready = 1'b0;

        // Halt coincides with the limit: halt wins
        bus2.cmd_valid = 1'b1;
        bus2.cmd_data  = 32'h6000_0000;
        tick();
        bus2.cmd_valid = 1'b0;
        repeat (15) tick();
        bus2.halt = 1'b1;
        tick();
        bus2.halt = 1'b0;
        check("tie_rsp_valid", {31'd0, bus2.rsp_valid}, 32'd1);
        check("tie_rsp_data", bus2.rsp_data, 32'h0000_0010);
        bus2.rsp_ready = 1'b1;
        tick();
        bus2.rsp_ready = 1'b0;

        // Reset during RUN
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h6000_0000;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rstrun_alive_busy", {30'd0, bus.alive, bus.busy}, 32'd0);
        check("rstrun_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("rstrun_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Reset during WR, then a normal RF write
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h0000_0003;
        tick();
        bus.cmd_data  = 32'hDEAD_BEEF;
        tick();
        check("rstwr_pre_wren", {31'd0, bus.mau_wren_im}, 32'd1);
        bus.cmd_data  = 32'h5555_5555;
        rst = 1'b1;
        tick();
        check("rstwr_wren", {29'd0, bus.mau_wren_im, bus.mau_wren_dm, bus.mau_wren_rf}, 32'd0);
        check("rstwr_addr_im", bus.mau_address_im, 32'd0);
        check("rstwr_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h4005_0001;
        tick();
        bus.cmd_data  = 32'h1234_5678;
        tick();
        bus.cmd_valid = 1'b0;
        check("post_rst_wren_rf", {31'd0, bus.mau_wren_rf}, 32'd1);
        check("post_rst_addr_rf", bus.mau_address_rf, 32'h0000_0014);
        check("post_rst_data_rf", bus.mau_write_data_rf, 32'h1234_5678);
        tick();
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mau_controller.md
# mau_controller

Host-side memory access unit that sits directly upstream of `cpu` and drives its `mau_*`, `alive` and `halt` ports. It accepts a 32-bit command word stream from the host link. It loads instruction memory, data memory and the register file, then releases the CPU by raising `alive` and waits for `halt` or a cycle limit. It reads memory contents back onto a 32-bit response stream.

## Interface
- `MAX_CYCLES`, default 32'd1_000_000: run watchdog limit, in cycles with `alive` high.
- `READ_LATENCY`, default 2: cycles from address drive to valid `mau_read_data_*`; legal range 1..7.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid` / `cmd_ready` / `cmd_data`  in/out/in  1/1/32  host command stream; a word transfers when valid & ready.
- `rsp_valid` / `rsp_ready` / `rsp_data`  out/in/out  1/1/32  response stream; a word transfers when valid & ready.
- `mau_address_im/dm/rf`  out  32 each  byte address, always word-aligned.
- `mau_write_data_im/dm/rf`  out  32 each  write data.
- `mau_wren_im/dm/rf`  out  1 each  one-cycle write strobe.
- `mau_read_data_im/dm/rf`  in  32 each  read data returned from `cpu`.
- `alive`  out  1  CPU run enable; CPU is held in reset while low.
- `halt`  in  1  CPU halted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Header word fields:
  - [31] op: 0 = write, 1 = read.
  - [30:29] target: 00 = IM, 01 = DM, 10 = RF, 11 = RUN.
  - [28:16] base word index B (13 bits).
  - [15:0] count N.
- Write (op=0, target≠11): the next N accepted data words go to word index (B+i) mod 8192. The byte address is that index shifted left by 2.
- Read (op=1, target≠11): N response words are returned, one per address, in ascending order.
- RUN (target 11, op and fields ignored):
  - `alive` goes high; the cycle counter C is cleared and then counts each cycle that `alive` is high.
  - The run ends on the first cycle `halt`=1 while `alive`=1, or when C reaches MAX_CYCLES.
  - Response word: [31] = timeout flag (1 = limit hit without halt), [30:0] = C saturated at 2^31-1.
- State machine:
  - IDLE → header accepted → WR, RD_ADDR or RUN.
  - WR → after N data words → IDLE.
  - RD_ADDR → RD_WAIT (READ_LATENCY cycles) → RD_PUSH → after rsp accepted: RD_ADDR, or IDLE once N words are done.
  - RUN → end condition → RUN_RSP → after rsp accepted → IDLE.
- N = 0 for write or read: return to IDLE the cycle after the header; no memory access and no response.
- Only the selected target's wren and address are driven. Non-selected wren stay 0 and their addresses hold their last value.
- `mau_write_data_*` all carry the same value; only the strobed target is meaningful.
- `alive` is 0 in every state except RUN, so memories are only touched while the CPU is stopped.

## Timing
- Reset values:
  - `cmd_ready` = 0 during reset, then 1 in IDLE from the first cycle after reset.
  - `rsp_valid` = 0, `rsp_data` = 0.
  - All `mau_wren_*` = 0; all `mau_address_*` and `mau_write_data_*` = 0.
  - `alive` = 0, `busy` = 0, state = IDLE.
- `cmd_ready` is 1 in IDLE and WR and 0 elsewhere; it is a registered output.
- Write strobe: a data word accepted in cycle t gives address, data and wren=1 registered in cycle t+1, for exactly one cycle. Back-to-back words give back-to-back strobes.
- Read:
  - Address is driven in the RD_ADDR cycle.
  - Data is sampled READ_LATENCY cycles later and `rsp_valid` rises the following cycle.
  - `rsp_data` and `rsp_valid` are held stable until `rsp_ready`.
- RUN:
  - `alive` rises the cycle after the header is accepted.
  - When the end condition holds in cycle t, `alive`=0 at t+1 and `rsp_valid`=1 at t+1.
  - C counts cycles with `alive`=1 up to and including cycle t.
  - If halt and the limit occur in the same cycle, halt wins (flag 0).
  - `halt` is ignored while `alive`=0.
- `rst` mid-operation: the next cycle gives reset values; `alive` drops and any pending response or strobe is discarded.

## Test plan
- Write IM: header 0x0000_0003 then 0xAAAA0001, 0xBBBB0002, 0xCCCC0003 → `mau_wren_im` pulses 3 cycles at addresses 0x0, 0x4, 0x8 with those data; DM/RF wren stay 0.
- Wrap: write DM with B=0x1FFF, N=2 → addresses 0x7FFC then 0x0000.
- Read RF: B=2, N=2 with `rsp_ready` toggling 1/0 → 2 words from addresses 0x8 and 0xC; data held stable during stalls; READ_LATENCY=2 honoured.
- RUN, halt after 50 alive cycles → `alive` high exactly 50 cycles; response 0x0000_0032.
- RUN with MAX_CYCLES=16 and halt never asserted → response 0x8000_0010; halt and limit in the same cycle → flag 0.
- Assert `rst` during RUN and during WR → `alive`=0 and all wren 0 next cycle; IDLE; the next header is accepted normally.
